imm_ext_pipe: RTL

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pipe.sv | 89 ++++++++
 1 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate extender feeding a 2-entry in-order result FIFO.
// The head entry drives y; in_ready/out_valid depend only on the registered occupancy.
module imm_ext_pipe #(
    parameter int N = 32,
    parameter int I = N / 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [I-1:0] a,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y
);

    if (I < 2 || N < I + 2) begin : g_param_check
        $error("imm_ext_pipe: illegal configuration N=%0d I=%0d", N, I);
    end

    logic [N-1:0] sign_ext;
    logic [N-1:0] zero_ext;
    logic [N-1:0] ext_d;
    logic [N-1:0] head_q, head_d;
    logic [N-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         push;
    logic         pop;

    assign sign_ext = {{(N-I){a[I-1]}}, a};
    assign zero_ext = {{(N-I){1'b0}}, a};

    always_comb begin
        ext_d = sign_ext;
        case (mode)
            2'b00: ext_d = sign_ext;
            2'b01: ext_d = zero_ext;
            2'b10: ext_d = sign_ext << 2;
            2'b11: ext_d = {a, {(N-I){1'b0}}};
        endcase
    end

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign y         = out_valid ? head_q : '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is always entry 0; a pop shifts the tail forward and clears the vacated slot.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = ext_d;
                end else begin
                    tail_d = ext_d;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                tail_d  = '0;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                head_d = ext_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
